fft_bf_sched: RTL and testbench

In-place radix-2 FFT scheduler that initiates every butterfly of a 2^N_LOG2-point transform on the serial butterfly unit (`butterfly_ra2_seri`). It owns the initiator side of the `bf_go`/`bf_done` handshake:
- fetches operand pairs from the data RAM and twiddles from the twiddle ROM;
- issues `bf_go` and feeds operands;
- writes the `wren`-qualified results back in place.

It sits between the FFT top-level control and the data RAM, twiddle ROM and butterfly unit.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_bf_sched_if.sv | 41 ++++
 rtl/fft_addr_gen.sv | 62 ++++++
 rtl/fft_bf_sched.sv | 197 +++++++++++++++++++
 tb/tb_fft_bf_sched.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: scheduler state encoding, the {re,im} complex
// word, and the in-place radix-2 DIT address / twiddle-index helpers.
package fft_pkg;

   localparam int FFT_DW = 8;

   typedef struct packed {
      logic [FFT_DW-1:0] re;
      logic [FFT_DW-1:0] im;
   } cplx_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_A,
      ST_FETCH_B,
      ST_GO,
      ST_OPA,
      ST_OPB,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Upper operand address of butterfly j in stage s (caller truncates to N_LOG2 bits).
   function automatic logic [31:0] bf_addr_a(input logic [31:0] j, input logic [31:0] s);
      logic [31:0] span;
      span = 32'd1 << s;
      return ((j >> s) << (s + 32'd1)) + (j & (span - 32'd1));
   endfunction

   // Lower operand address: one span above A.
   function automatic logic [31:0] bf_addr_b(input logic [31:0] j, input logic [31:0] s);
      return bf_addr_a(j, s) + (32'd1 << s);
   endfunction

   // Twiddle ROM index for butterfly j in stage s of a 2^n_log2-point transform.
   function automatic logic [31:0] bf_tw_idx(input logic [31:0] j, input logic [31:0] s,
                                             input logic [31:0] n_log2);
      return (j & ((32'd1 << s) - 32'd1)) << (n_log2 - 32'd1 - s);
   endfunction

endpackage

// File: rtl/fft_bf_sched_if.sv
// Bundle of every non-clock signal between the butterfly scheduler and its
// environment (control, data RAM, twiddle ROM, serial butterfly unit).
// master = scheduler side, slave = environment side.
interface fft_bf_sched_if #(
   parameter int N_LOG2 = 3,
   parameter int DW     = 8
);
   logic                start;
   logic                busy;
   logic                done;
   logic                err;
   logic                rd_en;
   logic [N_LOG2-1:0]   rd_addr;
   logic [2*DW-1:0]     rd_data;
   logic                wr_en;
   logic [N_LOG2-1:0]   wr_addr;
   logic [2*DW-1:0]     wr_data;
   logic [N_LOG2-2:0]   tw_addr;
   logic [2*DW-1:0]     tw_data;
   logic                bf_go;
   logic                bf_done;
   logic [DW-1:0]       wx;
   logic [DW-1:0]       wy;
   logic [DW-1:0]       datax;
   logic [DW-1:0]       datay;
   logic                wren;
   logic [DW-1:0]       bfx;
   logic [DW-1:0]       bfy;

   modport master (
      input  start, rd_data, tw_data, bf_done, wren, bfx, bfy,
      output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data,
             tw_addr, bf_go, wx, wy, datax, datay
   );

   modport slave (
      output start, rd_data, tw_data, bf_done, wren, bfx, bfy,
      input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data,
             tw_addr, bf_go, wx, wy, datax, datay
   );
endinterface

// File: rtl/fft_addr_gen.sv
// Stage/butterfly counters for the in-place DIT schedule. Presents the A/B
// operand addresses and twiddle index of the current butterfly and flags the
// final butterfly of the transform. Requires N_LOG2 >= 2.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int N_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              adv_i,
   output logic [N_LOG2-1:0] a_o,
   output logic [N_LOG2-1:0] b_o,
   output logic [N_LOG2-2:0] tw_o,
   output logic              last_o
);

   localparam int SW = $clog2(N_LOG2);

   logic [SW-1:0]     s_q, s_d;
   logic [N_LOG2-2:0] j_q, j_d;

   // Counter registers.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= '0;
         j_q <= '0;
      end else begin
         s_q <= s_d;
         j_q <= j_d;
      end
   end

   // Next count: clear wins, otherwise step j and roll into the next stage.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      s_d = s_q;
      j_d = j_q;
      if (clr_i) begin
         s_d = '0;
         j_d = '0;
      end else if (adv_i) begin
         if (j_q == '1) begin
            j_d = '0;
            s_d = s_q + 1'b1;
         end else begin
            j_d = j_q + 1'b1;
         end
      end
   end

   // Address decode; truncation to the port width gives the modulo-N wrap.
   always_comb begin
      a_o    = N_LOG2'(bf_addr_a(32'(j_q), 32'(s_q)));
      b_o    = N_LOG2'(bf_addr_b(32'(j_q), 32'(s_q)));
      tw_o   = (N_LOG2-1)'(bf_tw_idx(32'(j_q), 32'(s_q), 32'(N_LOG2)));
      last_o = (s_q == SW'(N_LOG2 - 1)) && (j_q == '1);
   end

endmodule

// File: rtl/fft_bf_sched.sv
// In-place radix-2 DIT FFT butterfly scheduler. Fetches each A/B operand
// pair and its twiddle, starts the serial butterfly unit, streams the
// operands and writes the two results back in place.
// Optional macro FFT_SCHED_TIMEOUT_EN: bounds the butterfly wait to TIMEOUT
// cycles after GO and reports overruns on err; without it err is 0.
module fft_bf_sched
   import fft_pkg::*;
#(
   parameter int N_LOG2  = 3,
   parameter int DW      = 8,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   fft_bf_sched_if.master bus
);

   state_t            state_q, state_d;
   logic [2*DW-1:0]   a_data_q, a_data_d;
   logic [2*DW-1:0]   b_data_q, b_data_d;
   logic [2*DW-1:0]   tw_q, tw_d;
   logic [1:0]        wcnt_q, wcnt_d;
   logic              wr_en_q, wr_en_d;
   logic [N_LOG2-1:0] wr_addr_q, wr_addr_d;
   logic [2*DW-1:0]   wr_data_q, wr_data_d;

   logic              ag_clr;
   logic              ag_adv;
   logic [N_LOG2-1:0] a_addr;
   logic [N_LOG2-1:0] b_addr;
   logic [N_LOG2-2:0] tw_idx;
   logic              last_bf;
   logic              to_hit;

   fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (ag_clr),
      .adv_i  (ag_adv),
      .a_o    (a_addr),
      .b_o    (b_addr),
      .tw_o   (tw_idx),
      .last_o (last_bf)
   );

`ifdef FFT_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Cycles elapsed since GO, so err lands exactly TIMEOUT cycles after bf_go.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == ST_GO) begin
         to_cnt_d = '0;
      end else if (state_q inside {ST_OPA, ST_OPB, ST_WAIT}) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   // A bf_done arriving on the deadline cycle still wins.
   assign to_hit = (state_q == ST_WAIT) && !bus.bf_done && (to_cnt_q == TO_W'(TIMEOUT - 1));
`else
   localparam int unused_timeout = TIMEOUT;
   assign to_hit = 1'b0;
`endif

   assign bus.err     = to_hit;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

   // FSM state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         a_data_q  <= '0;
         b_data_q  <= '0;
         tw_q      <= '0;
         wcnt_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
         tw_q      <= tw_d;
         wcnt_q    <= wcnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Next state, datapath captures and state-decoded outputs.
   always_comb begin
      state_d   = state_q;
      a_data_d  = a_data_q;
      b_data_d  = b_data_q;
      tw_d      = tw_q;
      wcnt_d    = wcnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ag_clr    = 1'b0;
      ag_adv    = 1'b0;

      // busy drops in DONE so its falling edge coincides with the done pulse.
      bus.busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
      bus.done    = 1'b0;
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
      bus.tw_addr = '0;
      bus.bf_go   = 1'b0;
      bus.wx      = '0;
      bus.wy      = '0;
      bus.datax   = '0;
      bus.datay   = '0;

      case (state_q)
         ST_IDLE: begin
            ag_clr = 1'b1;
            if (bus.start) begin
               state_d = ST_FETCH_A;
            end
         end
         ST_FETCH_A: begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = a_addr;
            bus.tw_addr = tw_idx;
            state_d     = ST_FETCH_B;
         end
         ST_FETCH_B: begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = b_addr;
            a_data_d    = bus.rd_data;
            tw_d        = bus.tw_data;
            state_d     = ST_GO;
         end
         ST_GO: begin
            bus.bf_go = 1'b1;
            bus.wx    = tw_q[2*DW-1:DW];
            bus.wy    = tw_q[DW-1:0];
            b_data_d  = bus.rd_data;
            wcnt_d    = '0;
            state_d   = ST_OPA;
         end
         ST_OPA: begin
            bus.datax = a_data_q[2*DW-1:DW];
            bus.datay = a_data_q[DW-1:0];
            state_d   = ST_OPB;
         end
         ST_OPB: begin
            bus.datax = b_data_q[2*DW-1:DW];
            bus.datay = b_data_q[DW-1:0];
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            // First result goes to A, second to B; any further wren is dropped.
            if (bus.wren && (wcnt_q != 2'd2)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = (wcnt_q == 2'd0) ? a_addr : b_addr;
               wr_data_d = {bus.bfx, bus.bfy};
               wcnt_d    = wcnt_q + 2'd1;
            end
            if (bus.bf_done) begin
               if (last_bf) begin
                  state_d = ST_DONE;
               end else begin
                  ag_adv  = 1'b1;
                  state_d = ST_FETCH_A;
               end
            end else if (to_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            bus.done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fft_bf_sched.sv
// Directed bench for fft_bf_sched: data RAM / twiddle ROM models, a
// programmable butterfly-unit model, and a negedge event monitor.
module tb_fft_bf_sched;
   import fft_pkg::*;

   localparam int N_LOG2  = 3;
   localparam int DW      = 8;
   localparam int TIMEOUT = 64;
   localparam int NBF     = 12;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   fft_bf_sched_if #(.N_LOG2(N_LOG2), .DW(DW)) bus ();

   fft_bf_sched #(.N_LOG2(N_LOG2), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected (A,B,tw) per bf_go, hand-derived for N=8.
   int exp_a  [NBF] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_b  [NBF] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw [NBF] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   // Data RAM (reloaded from ram_init during reset) and twiddle ROM, 1-cycle read.
   cplx_t ram      [8];
   cplx_t ram_init [8];
   cplx_t rom      [4];

   always @(posedge clk) begin
      if (rst) ram <= ram_init;
      else if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
      if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
      bus.tw_data <= rom[bus.tw_addr];
   end

   // Butterfly model: k = cycles since bf_go; wren at k==w1/w2/w3, bf_done at k==dn (-1 = never).
   int    k;
   int    w1, w2, w3, dn;
   cplx_t r1, r2;

   always @(posedge clk) begin
      if (rst) k <= 0;
      else if (bus.bf_go) k <= 1;
      else if (k != 0 && k < 5000) k <= k + 1;
   end

   assign bus.wren    = (k == w1) || (k == w2) || (k == w3);
   assign bus.bf_done = (k == dn);
   assign bus.bfx     = (k == w1) ? r1.re : r2.re;
   assign bus.bfy     = (k == w1) ? r1.im : r2.im;

   // Event monitor.
   int          cyc = 0;
   int          go_n, fa_n, wr_n, done_n, err_n, done_cyc, err_cyc;
   logic        done_busy, rd_prev;
   int          cur_a, cur_b, cur_tw;
   int          go_a [16], go_b [16], go_tw [16], go_cyc [16], fa_cyc [16];
   int          wr_addr_l [32], wr_cyc [32];
   logic [15:0] wr_data_l [32];
   logic [7:0]  wx0, wy0, opa_x, opa_y, opb_x, opb_y;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         go_n = 0; fa_n = 0; wr_n = 0; done_n = 0; err_n = 0; rd_prev = 1'b0;
      end else begin
         if (bus.rd_en && !rd_prev) begin
            if (fa_n < 16) fa_cyc[fa_n] = cyc;
            fa_n++;
            cur_a  = int'(bus.rd_addr);
            cur_tw = int'(bus.tw_addr);
         end
         if (bus.rd_en && rd_prev) cur_b = int'(bus.rd_addr);
         if (bus.bf_go) begin
            if (go_n < 16) begin
               go_a[go_n] = cur_a; go_b[go_n] = cur_b; go_tw[go_n] = cur_tw; go_cyc[go_n] = cyc;
            end
            if (go_n == 0) begin wx0 = bus.wx; wy0 = bus.wy; end
            go_n++;
         end
         if (go_n == 1 && cyc == go_cyc[0] + 1) begin opa_x = bus.datax; opa_y = bus.datay; end
         if (go_n == 1 && cyc == go_cyc[0] + 2) begin opb_x = bus.datax; opb_y = bus.datay; end
         if (bus.wr_en) begin
            if (wr_n < 32) begin
               wr_addr_l[wr_n] = int'(bus.wr_addr); wr_data_l[wr_n] = bus.wr_data; wr_cyc[wr_n] = cyc;
            end
            wr_n++;
         end
         if (bus.done) begin done_n++; done_cyc = cyc; done_busy = bus.busy; end
         if (bus.err) begin err_n++; err_cyc = cyc; end
         rd_prev = bus.rd_en;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_model(input int a, input int b, input int c, input int d);
      w1 = a; w2 = b; w3 = c; dn = d;
   endtask

   task automatic begin_run();
      rst = 1'b1; bus.start = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && done_n == 0; i++) tick();
   endtask

   task automatic wait_go(input int n, input int limit);
      for (int i = 0; i < limit && go_n < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      set_model(-1, -1, -1, -1);
      r1 = '{re: 8'd10, im: 8'd20};
      r2 = '{re: 8'd30, im: 8'd40};
      for (int i = 0; i < 8; i++) ram_init[i] = '{re: 8'(i), im: 8'(i + 50)};
      ram_init[0] = '{re: 8'd133, im: 8'd95};
      ram_init[1] = '{re: 8'd128, im: 8'd100};
      rom[0] = '{re: 8'd20, im: 8'd35};
      rom[1] = '{re: 8'd1,  im: 8'd2};
      rom[2] = '{re: 8'd3,  im: 8'd4};
      rom[3] = '{re: 8'd5,  im: 8'd6};
      tick(); tick();

      // Reset state.
      check("rst_busy",  32'(bus.busy),  0);
      check("rst_done",  32'(bus.done),  0);
      check("rst_err",   32'(bus.err),   0);
      check("rst_rd_en", 32'(bus.rd_en), 0);
      check("rst_wr_en", 32'(bus.wr_en), 0);
      check("rst_bf_go", 32'(bus.bf_go), 0);
      check("rst_wx",    32'(bus.wx),    0);
      check("rst_datax", 32'(bus.datax), 0);

      // Full transform, wren at OPB+2/+3, bf_done at OPB+4.
      set_model(4, 5, -1, 6);
      begin_run();
      wait_done(400);
      tick(); tick();
      check("a_done_cnt", 32'(done_n), 1);
      check("a_go_cnt",   32'(go_n),   NBF);
      for (int i = 0; i < NBF; i++) begin
         check($sformatf("a_go%0d_A", i),  32'(go_a[i]),  32'(exp_a[i]));
         check($sformatf("a_go%0d_B", i),  32'(go_b[i]),  32'(exp_b[i]));
         check($sformatf("a_go%0d_tw", i), 32'(go_tw[i]), 32'(exp_tw[i]));
      end
      check("a_fetch_to_go",   32'(go_cyc[0] - fa_cyc[0]), 2);
      check("a_go_to_refetch", 32'(fa_cyc[1] - go_cyc[0]), 7);
      check("a_wx",  32'(wx0),   20);
      check("a_wy",  32'(wy0),   35);
      check("a_opa_x", 32'(opa_x), 133);
      check("a_opa_y", 32'(opa_y), 95);
      check("a_opb_x", 32'(opb_x), 128);
      check("a_opb_y", 32'(opb_y), 100);
      check("a_wr_cnt",   32'(wr_n), 24);
      check("a_wr0_addr", 32'(wr_addr_l[0]), 0);
      check("a_wr0_data", 32'(wr_data_l[0]), 32'h0A14);
      check("a_wr1_addr", 32'(wr_addr_l[1]), 1);
      check("a_wr1_data", 32'(wr_data_l[1]), 32'h1E28);
      check("a_wr_latency", 32'(wr_cyc[0] - go_cyc[0]), 5);
      check("a_done_cycle", 32'(done_cyc - go_cyc[NBF-1]), 7);
      check("a_busy_at_done", 32'(done_busy), 0);
      check("a_busy_after", 32'(bus.busy), 0);
      check("a_ram0", 32'(ram[0]), 32'h0A14);
      check("a_ram7", 32'(ram[7]), 32'h1E28);

      // Second wren coincides with bf_done; a stray wren lands in the next FETCH_A.
      set_model(4, 6, 7, 6);
      begin_run();
      wait_done(400);
      tick(); tick();
      check("b_done_cnt",  32'(done_n), 1);
      check("b_go_cnt",    32'(go_n), NBF);
      check("b_wr_cnt",    32'(wr_n), 24);
      check("b_wr1_addr",  32'(wr_addr_l[1]), 1);
      check("b_wr1_data",  32'(wr_data_l[1]), 32'h1E28);
      check("b_wr1_cycle", 32'(wr_cyc[1] - go_cyc[0]), 7);
      check("b_refetch",   32'(fa_cyc[1] - go_cyc[0]), 7);

      // Third wren inside WAIT is dropped.
      set_model(4, 5, 6, 7);
      begin_run();
      wait_done(400);
      tick(); tick();
      check("c_done_cnt", 32'(done_n), 1);
      check("c_go_cnt",   32'(go_n), NBF);
      check("c_wr_cnt",   32'(wr_n), 24);
      check("c_wr2_addr", 32'(wr_addr_l[2]), 2);

      // Only one wren per butterfly: bf_done still advances.
      set_model(4, -1, -1, 6);
      begin_run();
      wait_done(400);
      tick(); tick();
      check("d_done_cnt", 32'(done_n), 1);
      check("d_go_cnt",   32'(go_n), NBF);
      check("d_wr_cnt",   32'(wr_n), NBF);

      // start while busy is ignored.
      set_model(4, 5, -1, 6);
      begin_run();
      wait_go(3, 100);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(400);
      repeat (20) tick();
      check("e_go_cnt",   32'(go_n), NBF);
      check("e_done_cnt", 32'(done_n), 1);
      check("e_busy",     32'(bus.busy), 0);

      // Reset during WAIT.
      set_model(4, 5, -1, 6);
      begin_run();
      wait_go(2, 100);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("f_busy",    32'(bus.busy), 0);
      check("f_done",    32'(bus.done), 0);
      check("f_err",     32'(bus.err), 0);
      check("f_rd_en",   32'(bus.rd_en), 0);
      check("f_rd_addr", 32'(bus.rd_addr), 0);
      check("f_tw_addr", 32'(bus.tw_addr), 0);
      check("f_wr_en",   32'(bus.wr_en), 0);
      check("f_wr_addr", 32'(bus.wr_addr), 0);
      check("f_wr_data", 32'(bus.wr_data), 0);
      check("f_bf_go",   32'(bus.bf_go), 0);
      check("f_wx",      32'(bus.wx), 0);
      check("f_wy",      32'(bus.wy), 0);
      check("f_datax",   32'(bus.datax), 0);
      check("f_datay",   32'(bus.datay), 0);
      tick();
      rst = 1'b0;
      repeat (30) tick();
      check("f_go_after",   32'(go_n), 0);
      check("f_wr_after",   32'(wr_n), 0);
      check("f_done_after", 32'(done_n), 0);
      check("f_busy_after", 32'(bus.busy), 0);

      // Butterfly never finishes.
      set_model(4, 5, -1, -1);
      begin_run();
`ifdef FFT_SCHED_TIMEOUT_EN
      for (int i = 0; i < 300 && err_n == 0; i++) tick();
      check("g_err_cnt",   32'(err_n), 1);
      check("g_err_cycle", 32'(err_cyc - go_cyc[0]), TIMEOUT);
      tick();
      check("g_busy",     32'(bus.busy), 0);
      repeat (10) tick();
      check("g_done_cnt", 32'(done_n), 0);
      check("g_go_cnt",   32'(go_n), 1);
      check("g_err_once", 32'(err_n), 1);
`else
      repeat (1000) tick();
      check("g_busy",     32'(bus.busy), 1);
      check("g_err",      32'(bus.err), 0);
      check("g_err_cnt",  32'(err_n), 0);
      check("g_go_cnt",   32'(go_n), 1);
      check("g_done_cnt", 32'(done_n), 0);
      check("g_rd_en",    32'(bus.rd_en), 0);
`endif
      rst = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
